// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequences an external up/down counter between two turn-around
// limits, dwelling a programmable number of cycles at each limit, for a programmed
// number of up/down passes (or endlessly when loops == 0).
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start, abort       run request (IDLE only) / immediate termination
//   up_lim, lo_lim     upper / lower turn-around values (latched on start)
//   dwell, loops       hold cycles at each limit / number of passes (latched on start)
//   cntr               registered count fed back from the driven counter
//   en, hold, up_down  counter controls (hold is the only path combinational from cntr)
//   busy, done, err    status: running / one-cycle completion / one-cycle parameter error
//   loop_cnt           completed passes
module counter_seq_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  up_lim,
  input  logic [W-1:0]  lo_lim,
  input  logic [DW-1:0] dwell,
  input  logic [DW-1:0] loops,
  input  logic [W-1:0]  cntr,
  output logic          en,
  output logic          hold,
  output logic          up_down,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] loop_cnt
);

  localparam logic [DW-1:0] DwOne = DW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StUp,
    StDwellHi,
    StDown,
    StDwellLo,
    StFin
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  up_lim_q, lo_lim_q;
  logic [DW-1:0] dwell_q, loops_q;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DW-1:0] loop_cnt_q, loop_cnt_d;
  logic          latch;
  logic          err_d;
  logic          en_q, up_down_q, busy_q, done_q, err_q;

  logic          at_hi, at_lo;
  logic [DW-1:0] loop_inc;
  logic          pass_fin;

  assign at_hi    = (cntr >= up_lim_q);
  assign at_lo    = (cntr <= lo_lim_q);
  assign loop_inc = loop_cnt_q + DwOne;
  // A finite run ends once the pass just completed reaches the programmed count.
  assign pass_fin = (loops_q != '0) && (loop_inc == loops_q);

  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    loop_cnt_d  = loop_cnt_q;
    latch       = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          latch = 1'b1;
          if (lo_lim >= up_lim) begin
            err_d = 1'b1;
          end else begin
            state_d    = StUp;
            loop_cnt_d = '0;
          end
        end
      end
      StUp: begin
        if (at_hi) begin
          if (dwell_q == '0) begin
            state_d = StDown;
          end else begin
            state_d     = StDwellHi;
            dwell_cnt_d = dwell_q - DwOne;
          end
        end
      end
      StDwellHi: begin
        if (dwell_cnt_q == '0) state_d = StDown;
        else                   dwell_cnt_d = dwell_cnt_q - DwOne;
      end
      StDown: begin
        if (at_lo) begin
          if (dwell_q == '0) begin
            loop_cnt_d = loop_inc;
            state_d    = pass_fin ? StFin : StUp;
          end else begin
            state_d     = StDwellLo;
            dwell_cnt_d = dwell_q - DwOne;
          end
        end
      end
      StDwellLo: begin
        if (dwell_cnt_q == '0) begin
          loop_cnt_d = loop_inc;
          state_d    = pass_fin ? StFin : StUp;
        end else begin
          dwell_cnt_d = dwell_cnt_q - DwOne;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over every transition; pending pass/dwell updates are dropped.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      dwell_cnt_d = dwell_cnt_q;
      loop_cnt_d  = loop_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      up_lim_q    <= '0;
      lo_lim_q    <= '0;
      dwell_q     <= '0;
      loops_q     <= '0;
      dwell_cnt_q <= '0;
      loop_cnt_q  <= '0;
      en_q        <= 1'b0;
      up_down_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      loop_cnt_q  <= loop_cnt_d;
      err_q       <= err_d;
      if (latch) begin
        up_lim_q <= up_lim;
        lo_lim_q <= lo_lim;
        dwell_q  <= dwell;
        loops_q  <= loops;
      end
      // Status outputs are registered from the next state so they change only at the edge.
      en_q      <= (state_d != StIdle) && (state_d != StFin);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StFin);
      // Direction is implied by the state: the dwell states keep the preceding direction.
      up_down_q <= (state_d == StUp) || (state_d == StDwellHi);
    end
  end

  always_comb begin
    hold = 1'b1;
    if (state_q == StUp)   hold = at_hi;
    if (state_q == StDown) hold = at_lo;
  end

  assign en       = en_q;
  assign up_down  = up_down_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign loop_cnt = loop_cnt_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, abort;
  logic [7:0] up_lim, lo_lim;
  logic [3:0] dwell, loops;
  logic [7:0] cntr;
  logic       en, hold, up_down, busy, done, err;
  logic [3:0] loop_cnt;

  logic       load_en;
  logic [7:0] load_val;

  int checks = 0;
  int errors = 0;

  counter_seq_ctrl #(.W(8), .DW(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .up_lim   (up_lim),
    .lo_lim   (lo_lim),
    .dwell    (dwell),
    .loops    (loops),
    .cntr     (cntr),
    .en       (en),
    .hold     (hold),
    .up_down  (up_down),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .loop_cnt (loop_cnt)
  );

  always #5 clk = ~clk;

  // Driven counter: +/-1 only when enabled and not frozen; bench may preload it.
  always @(posedge clk) begin
    if (load_en)             cntr <= load_val;
    else if (en && !hold)    cntr <= up_down ? cntr + 8'd1 : cntr - 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sequence statistics gathered by run_seq.
  int         n_up, n_down, n_hi, n_lo, n_done;
  logic [7:0] lim_hi, lim_lo, prev;
  logic [7:0] trace[$];

  task automatic start_seq(input logic [7:0] u, input logic [7:0] l, input logic [3:0] d,
                           input logic [3:0] lp, input logic [7:0] c0);
    load_val = c0; load_en = 1'b1;
    step();
    load_en = 1'b0;
    up_lim = u; lo_lim = l; dwell = d; loops = lp; lim_hi = u; lim_lo = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Observe cycles until busy drops; a cycle budget keeps the bench from hanging.
  task automatic run_seq(input string name, input int max_cyc);
    logic timed_out;
    n_up = 0; n_down = 0; n_hi = 0; n_lo = 0; n_done = 0;
    trace.delete();
    trace.push_back(cntr);
    prev = cntr;
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (en && !hold) begin
        if (up_down) n_up++;
        else         n_down++;
      end
      if (en && hold && (cntr == prev)) begin
        if (cntr == lim_hi)      n_hi++;
        else if (cntr == lim_lo) n_lo++;
      end
      if (done) n_done++;
      if (cntr != trace[$]) trace.push_back(cntr);
      prev = cntr;
      step();
    end
    chk({name, "_timeout"}, 32'(timed_out), 0);
  endtask

  task automatic chk_trace(input string name, input logic [7:0] exp[$]);
    chk({name, "_trace_len"}, trace.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < trace.size()) chk({name, "_trace"}, trace[i], exp[i]);
    end
  endtask

  typedef struct {
    logic [7:0] up;
    logic [7:0] lo;
    logic       st;
    logic       ab;
    logic       e_err;
    logic       e_busy;
    logic       e_en;
    logic       e_ud;
    logic       e_hold;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic       saw_done;
    logic       found;
    logic [7:0] exp_q[$];

    //            up     lo     st    ab    err   busy  en    ud    hold
    vecs[0] = '{8'd5,  8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'd4,  8'd4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'd3,  8'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'd5,  8'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'd5,  8'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'd0,  8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'd255, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; load_en = 1'b0; load_val = 8'd0;
    up_lim = 8'd0; lo_lim = 8'd0; dwell = 4'd3; loops = 4'd1;
    cntr = 8'd0;
    #3;
    chk("rst_en", 32'(en), 0);
    chk("rst_hold", 32'(hold), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_loop_cnt", 32'(loop_cnt), 0);
    step();
    #4 rstn = 1'b1;
    step();

    // Single-start vectors from IDLE.
    for (int i = 0; i < 7; i++) begin
      load_val = 8'd0; load_en = 1'b1;
      step();
      load_en = 1'b0;
      up_lim = vecs[i].up; lo_lim = vecs[i].lo; start = vecs[i].st; abort = vecs[i].ab;
      dwell = 4'd3; loops = 4'd1;
      step();
      start = 1'b0; abort = 1'b0;
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d_up_down", i), 32'(up_down), 32'(vecs[i].e_ud));
      chk($sformatf("vec%0d_hold", i), 32'(hold), 32'(vecs[i].e_hold));
      step();
      chk($sformatf("vec%0d_err_pulse", i), 32'(err), 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk($sformatf("vec%0d_idle", i), 32'(busy), 0);
    end

    // Basic sequence: 5 up, dwell 3 at 5, down to 2, dwell 3, done.
    start_seq(8'd5, 8'd2, 4'd3, 4'd1, 8'd0);
    run_seq("basic", 100);
    chk("basic_n_up", n_up, 5);
    chk("basic_n_down", n_down, 3);
    chk("basic_dwell_hi", n_hi, 3);
    chk("basic_dwell_lo", n_lo, 3);
    chk("basic_done", n_done, 1);
    chk("basic_loop_cnt", 32'(loop_cnt), 1);
    chk("basic_cntr", 32'(cntr), 2);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2};
    chk_trace("basic", exp_q);
    step(); step();
    chk("idle_loop_cnt_hold", 32'(loop_cnt), 1);
    chk("idle_en", 32'(en), 0);

    // Zero dwell, two passes; the valid start clears loop_cnt.
    start_seq(8'd3, 8'd0, 4'd0, 4'd2, 8'd0);
    chk("zd_loop_cnt_clear", 32'(loop_cnt), 0);
    run_seq("zd", 100);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0,
              8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};
    chk_trace("zd", exp_q);
    chk("zd_done", n_done, 1);
    chk("zd_loop_cnt", 32'(loop_cnt), 2);
    chk("zd_dwell_hi", n_hi, 0);

    // Abort while dwelling at the upper limit in an endless run.
    start_seq(8'd5, 8'd2, 4'd3, 4'd0, 8'd0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      prev = cntr;
      step();
      if (busy && en && hold && up_down && (cntr == 8'd5) && (prev == 8'd5)) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_reach_dwell", 32'(found), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_en", 32'(en), 0);
    chk("abort_hold", 32'(hold), 1);
    saw_done = done;
    for (int i = 0; i < 3; i++) begin
      step();
      saw_done = saw_done | done;
    end
    chk("abort_no_done", 32'(saw_done), 0);
    chk("abort_cntr", 32'(cntr), 5);

    // Limit already reached on entry; start while busy is ignored.
    start_seq(8'd8, 8'd1, 4'd0, 4'd1, 8'd10);
    chk("entry_hold", 32'(hold), 1);
    chk("entry_up_down", 32'(up_down), 1);
    start = 1'b1;
    step();
    chk("entry_down_dir", 32'(up_down), 0);
    chk("entry_down_cnt", 32'(en && !hold), 1);
    chk("entry_no_inc", 32'(cntr), 10);
    step(); step(); step();
    start = 1'b0;
    chk("busy_start_cntr", 32'(cntr), 7);
    chk("busy_start_loop_cnt", 32'(loop_cnt), 0);
    run_seq("entry", 100);
    chk("entry_n_up", n_up, 0);
    chk("entry_n_down", n_down, 6);
    chk("entry_done", n_done, 1);
    chk("entry_loop_cnt", 32'(loop_cnt), 1);
    chk("entry_cntr", 32'(cntr), 1);

    // Asynchronous reset while counting down.
    start_seq(8'd5, 8'd2, 4'd3, 4'd1, 8'd0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (en && !hold && !up_down) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid_reach_down", 32'(found), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_en", 32'(en), 0);
    chk("rstmid_hold", 32'(hold), 1);
    chk("rstmid_up_down", 32'(up_down), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_done", 32'(done), 0);
    chk("rstmid_err", 32'(err), 0);
    chk("rstmid_loop_cnt", 32'(loop_cnt), 0);
    prev = cntr;
    step(); step();
    #2 rstn = 1'b1;
    step();
    chk("rstmid_after_busy", 32'(busy), 0);
    chk("rstmid_after_done", 32'(done), 0);
    chk("rstmid_cntr_frozen", 32'(cntr), 32'(prev));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
